// File: rtl/i2c_slave_regfile.sv
// I2C slave responder with an internal byte register file.
// SCL/SDA are oversampled on clk. The block decodes START/STOP and the
// device address, then runs register-write, pointer-set and sequential-read
// transfers. It never stretches the clock.
module i2c_slave_regfile #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50,
  parameter int         NUM_REGS   = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl_pad_i,
  input  logic       sda_pad_i,
  output logic       sda_pad_o,
  output logic       sda_padoen_o,
  output logic       busy_o,
  output logic       reg_wr_o,
  output logic [7:0] reg_addr_o,
  output logic [7:0] reg_data_o
);

  localparam int PW = $clog2(NUM_REGS);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    ADDR     = 4'd1,
    ADDR_ACK = 4'd2,
    PTR      = 4'd3,
    PTR_ACK  = 4'd4,
    WDATA    = 4'd5,
    WACK     = 4'd6,
    RDATA    = 4'd7,
    RACK     = 4'd8,
    WAIT     = 4'd9
  } state_t;

  // Synchronizer and history flops. They reset to the idle-bus level so that
  // reset itself cannot look like a START.
  logic scl_meta_r, scl_sync_r, scl_hist_r;
  logic sda_meta_r, sda_sync_r, sda_hist_r;

  // Bus events decoded from the synchronized lines.
  logic scl_rise_s, scl_fall_s, start_s, stop_s;
  logic [7:0] rx_byte_s;
  logic [7:0] rd_data_s;

  // Transfer state.
  state_t     state_r;
  logic [2:0] bit_cnt_r;
  logic [7:0] shift_r;
  logic       rw_r;
  // Second half of a two-event phase: ACK driven (ack states), or the master
  // ACK already seen (RACK).
  logic       phase_r;
  logic [PW-1:0] ptr_r;
  logic [7:0] regs_r [NUM_REGS];

  // Registered outputs.
  logic       sda_oen_r;
  logic       busy_r;
  logic       reg_wr_r;
  logic [7:0] reg_addr_r;
  logic [7:0] reg_data_r;

  // Bring both pad lines into the clk domain and keep one cycle of history.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scl_meta_r <= 1'b1;
      scl_sync_r <= 1'b1;
      scl_hist_r <= 1'b1;
      sda_meta_r <= 1'b1;
      sda_sync_r <= 1'b1;
      sda_hist_r <= 1'b1;
    end else begin
      scl_meta_r <= scl_pad_i;
      scl_sync_r <= scl_meta_r;
      scl_hist_r <= scl_sync_r;
      sda_meta_r <= sda_pad_i;
      sda_sync_r <= sda_meta_r;
      sda_hist_r <= sda_sync_r;
    end
  end

  // Decode SCL edges, START/STOP and the byte being completed on this rise.
  always_comb begin
    scl_rise_s = 1'b0;
    scl_fall_s = 1'b0;
    start_s    = 1'b0;
    stop_s     = 1'b0;
    rx_byte_s  = {shift_r[6:0], sda_sync_r};
    rd_data_s  = regs_r[ptr_r];
    if (scl_sync_r && !scl_hist_r) begin
      scl_rise_s = 1'b1;
    end else begin
      scl_rise_s = 1'b0;
    end
    if (!scl_sync_r && scl_hist_r) begin
      scl_fall_s = 1'b1;
    end else begin
      scl_fall_s = 1'b0;
    end
    if (scl_sync_r && sda_hist_r && !sda_sync_r) begin
      start_s = 1'b1;
    end else begin
      start_s = 1'b0;
    end
    if (scl_sync_r && !sda_hist_r && sda_sync_r) begin
      stop_s = 1'b1;
    end else begin
      stop_s = 1'b0;
    end
  end

  // Protocol FSM: START/STOP win over SCL edges; data is taken on SCL rise
  // and SDA is only changed on SCL fall.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      bit_cnt_r  <= 3'd0;
      shift_r    <= 8'h00;
      rw_r       <= 1'b0;
      phase_r    <= 1'b0;
      ptr_r      <= '0;
      sda_oen_r  <= 1'b1;
      busy_r     <= 1'b0;
      reg_wr_r   <= 1'b0;
      reg_addr_r <= 8'h00;
      reg_data_r <= 8'h00;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_r[i] <= 8'h00;
      end
    end else begin
      reg_wr_r <= 1'b0;
      if (start_s) begin
        state_r   <= ADDR;
        bit_cnt_r <= 3'd0;
        phase_r   <= 1'b0;
        sda_oen_r <= 1'b1;
      end else if (stop_s) begin
        // A partially received byte is simply dropped here.
        state_r   <= IDLE;
        bit_cnt_r <= 3'd0;
        phase_r   <= 1'b0;
        sda_oen_r <= 1'b1;
        busy_r    <= 1'b0;
      end else if (scl_rise_s) begin
        case (state_r)
          ADDR: begin
            shift_r   <= rx_byte_s;
            bit_cnt_r <= bit_cnt_r + 3'd1;
            if (bit_cnt_r == 3'd7) begin
              phase_r <= 1'b0;
              if (rx_byte_s[7:1] == SLAVE_ADDR) begin
                state_r <= ADDR_ACK;
                rw_r    <= rx_byte_s[0];
                busy_r  <= 1'b1;
              end else begin
                state_r <= WAIT;
                busy_r  <= 1'b0;
              end
            end
          end
          PTR: begin
            shift_r   <= rx_byte_s;
            bit_cnt_r <= bit_cnt_r + 3'd1;
            if (bit_cnt_r == 3'd7) begin
              ptr_r   <= rx_byte_s[PW-1:0];
              phase_r <= 1'b0;
              state_r <= PTR_ACK;
            end
          end
          WDATA: begin
            shift_r   <= rx_byte_s;
            bit_cnt_r <= bit_cnt_r + 3'd1;
            if (bit_cnt_r == 3'd7) begin
              regs_r[ptr_r] <= rx_byte_s;
              reg_wr_r      <= 1'b1;
              reg_addr_r    <= 8'(ptr_r);
              reg_data_r    <= rx_byte_s;
              ptr_r         <= ptr_r + PW'(1);
              phase_r       <= 1'b0;
              state_r       <= WACK;
            end
          end
          RACK: begin
            if (!phase_r) begin
              if (!sda_sync_r) begin
                // Master ACK: advance now, load the next byte on the fall.
                ptr_r   <= ptr_r + PW'(1);
                phase_r <= 1'b1;
              end else begin
                state_r <= WAIT;
              end
            end
          end
          default: begin
          end
        endcase
      end else if (scl_fall_s) begin
        case (state_r)
          ADDR_ACK: begin
            if (!phase_r) begin
              sda_oen_r <= 1'b0;
              phase_r   <= 1'b1;
            end else begin
              phase_r   <= 1'b0;
              bit_cnt_r <= 3'd0;
              if (rw_r) begin
                state_r   <= RDATA;
                shift_r   <= rd_data_s;
                sda_oen_r <= rd_data_s[7];
              end else begin
                state_r   <= PTR;
                sda_oen_r <= 1'b1;
              end
            end
          end
          PTR_ACK, WACK: begin
            if (!phase_r) begin
              sda_oen_r <= 1'b0;
              phase_r   <= 1'b1;
            end else begin
              sda_oen_r <= 1'b1;
              phase_r   <= 1'b0;
              bit_cnt_r <= 3'd0;
              state_r   <= WDATA;
            end
          end
          RDATA: begin
            if (bit_cnt_r == 3'd7) begin
              sda_oen_r <= 1'b1;
              phase_r   <= 1'b0;
              bit_cnt_r <= 3'd0;
              state_r   <= RACK;
            end else begin
              shift_r   <= {shift_r[6:0], 1'b0};
              sda_oen_r <= shift_r[6];
              bit_cnt_r <= bit_cnt_r + 3'd1;
            end
          end
          RACK: begin
            if (phase_r) begin
              shift_r   <= rd_data_s;
              sda_oen_r <= rd_data_s[7];
              bit_cnt_r <= 3'd0;
              phase_r   <= 1'b0;
              state_r   <= RDATA;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign sda_pad_o    = 1'b0;
  assign sda_padoen_o = sda_oen_r;
  assign busy_o       = busy_r;
  assign reg_wr_o     = reg_wr_r;
  assign reg_addr_o   = reg_addr_r;
  assign reg_data_o   = reg_data_r;

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Bench for i2c_slave_regfile: a bit-banged I2C master drives the pads, a
// register-file model predicts writes and read data, and a monitor compares
// every reg_wr_o pulse against a queue of expected writes.
module tb_i2c_slave_regfile;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       scl_m;
  logic       sda_m;
  logic       sda_line;
  logic       sda_pad_o;
  logic       sda_padoen_o;
  logic       busy_o;
  logic       reg_wr_o;
  logic [7:0] reg_addr_o;
  logic [7:0] reg_data_o;

  always #5 clk = ~clk;

  // Wired-AND SDA: master level AND slave pull-down.
  assign sda_line = sda_m & (sda_padoen_o | sda_pad_o);

  i2c_slave_regfile #(.SLAVE_ADDR(7'h50), .NUM_REGS(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .scl_pad_i    (scl_m),
    .sda_pad_i    (sda_line),
    .sda_pad_o    (sda_pad_o),
    .sda_padoen_o (sda_padoen_o),
    .busy_o       (busy_o),
    .reg_wr_o     (reg_wr_o),
    .reg_addr_o   (reg_addr_o),
    .reg_data_o   (reg_data_o)
  );

  typedef struct {
    int addr;
    int data;
  } wr_t;

  int         n_total = 0;
  int         n_pass  = 0;
  logic [7:0] m_regs [16];
  int         m_ptr;
  wr_t        wr_q [$];
  logic [7:0] wdata_q [$];

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic wait_q();
    repeat (4) @(negedge clk);
  endtask

  // One SCL clock: set SDA in the low phase, sample the line mid-high.
  task automatic clk_bit(input logic b, output logic s);
    wait_q();
    sda_m = b;
    wait_q();
    scl_m = 1'b1;
    wait_q();
    s = sda_line;
    wait_q();
    scl_m = 1'b0;
  endtask

  task automatic i2c_start();
    wait_q();
    sda_m = 1'b1;
    wait_q();
    scl_m = 1'b1;
    wait_q();
    sda_m = 1'b0;
    wait_q();
    scl_m = 1'b0;
  endtask

  task automatic i2c_stop();
    wait_q();
    sda_m = 1'b0;
    wait_q();
    scl_m = 1'b1;
    wait_q();
    sda_m = 1'b1;
    wait_q();
  endtask

  task automatic write_byte(input logic [7:0] b, output logic acked);
    logic s;
    for (int i = 7; i >= 0; i--) clk_bit(b[i], s);
    clk_bit(1'b1, s);
    acked = ~s;
  endtask

  task automatic read_byte(input logic master_ack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, s);
      d[i] = s;
    end
    clk_bit(~master_ack, s);
  endtask

  // Write transfer: pointer byte then every byte queued in wdata_q.
  task automatic wr_txn(input logic [7:0] p);
    logic       a;
    logic [7:0] b;
    wr_t        e;
    i2c_start();
    write_byte(8'hA0, a);
    check("addr_ack_w", int'(a), 1);
    check("busy_set", int'(busy_o), 1);
    write_byte(p, a);
    check("ptr_ack", int'(a), 1);
    m_ptr = int'(p) % 16;
    while (wdata_q.size() > 0) begin
      b = wdata_q.pop_front();
      e.addr = m_ptr;
      e.data = int'(b);
      wr_q.push_back(e);
      m_regs[m_ptr] = b;
      m_ptr = (m_ptr + 1) % 16;
      write_byte(b, a);
      check("data_ack", int'(a), 1);
    end
    i2c_stop();
    check("busy_clr", int'(busy_o), 0);
  endtask

  // Read n bytes, optionally setting the pointer first via repeated START.
  task automatic rd_txn(input logic set_ptr, input logic [7:0] p, input int n);
    logic       a;
    logic       last;
    logic [7:0] d;
    int         exp;
    if (set_ptr) begin
      i2c_start();
      write_byte(8'hA0, a);
      check("addr_ack_p", int'(a), 1);
      write_byte(p, a);
      check("ptr_ack_r", int'(a), 1);
      m_ptr = int'(p) % 16;
    end
    i2c_start();
    write_byte(8'hA1, a);
    check("addr_ack_r", int'(a), 1);
    for (int i = 0; i < n; i++) begin
      exp  = int'(m_regs[m_ptr]);
      last = (i == n - 1);
      read_byte(~last, d);
      check("rd_data", int'(d), exp);
      if (!last) m_ptr = (m_ptr + 1) % 16;
    end
    check("rel_after_nack", int'(sda_padoen_o), 1);
    i2c_stop();
    check("busy_clr_r", int'(busy_o), 0);
  endtask

  task automatic mis_txn(input logic [6:0] adr);
    logic a;
    i2c_start();
    write_byte({adr, 1'b0}, a);
    check("mis_nack", int'(a), 0);
    check("mis_busy", int'(busy_o), 0);
    write_byte(8'h00, a);
    check("mis_nack2", int'(a), 0);
    i2c_stop();
  endtask

  initial begin
    logic       a;
    logic       s;
    logic [6:0] ra;
    int         kind;
    int         n;

    fork
      // Monitor: every write pulse must match the oldest expected write.
      begin
        wr_t e;
        forever begin
          @(negedge clk);
          if (rst_n === 1'b1 && reg_wr_o === 1'b1) begin
            if (wr_q.size() == 0) begin
              check("spurious_wr", int'(reg_wr_o), 0);
            end else begin
              e = wr_q.pop_front();
              check("wr_addr", int'(reg_addr_o), e.addr);
              check("wr_data", int'(reg_data_o), e.data);
            end
          end
        end
      end
      begin
        #900000;
        $display("FAIL watchdog: time limit reached, expected run to complete");
        $fatal(1, "watchdog");
      end
    join_none

    for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
    m_ptr = 0;
    scl_m = 1'b1;
    sda_m = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_oen", int'(sda_padoen_o), 1);
    check("rst_busy", int'(busy_o), 0);
    check("rst_wr", int'(reg_wr_o), 0);
    check("rst_addr", int'(reg_addr_o), 0);
    check("rst_data", int'(reg_data_o), 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Directed: write 0x5A, 0xC3 at 3, read back through a repeated START.
    wdata_q = '{8'h5A, 8'hC3};
    wr_txn(8'h03);
    rd_txn(1'b1, 8'h03, 2);

    // Address mismatch.
    mis_txn(7'h51);

    // Pointer wrap.
    wdata_q = '{8'h11, 8'h22};
    wr_txn(8'h0F);
    rd_txn(1'b1, 8'h0F, 2);

    // Randomized mix of writes, reads and foreign addresses.
    for (int it = 0; it < 14; it++) begin
      kind = int'($urandom_range(0, 3));
      case (kind)
        0: begin
          n = int'($urandom_range(1, 4));
          for (int j = 0; j < n; j++) wdata_q.push_back(8'($urandom_range(0, 255)));
          wr_txn(8'($urandom_range(0, 255)));
        end
        1: rd_txn(1'b1, 8'($urandom_range(0, 255)), int'($urandom_range(1, 3)));
        2: rd_txn(1'b0, 8'h00, int'($urandom_range(1, 3)));
        default: begin
          ra = 7'($urandom_range(0, 127));
          if (ra == 7'h50) ra = 7'h2A;
          mis_txn(ra);
        end
      endcase
    end

    // Abort: STOP after 4 data bits must not write.
    i2c_start();
    write_byte(8'hA0, a);
    check("abort_addr_ack", int'(a), 1);
    write_byte(8'h05, a);
    check("abort_ptr_ack", int'(a), 1);
    m_ptr = 5;
    for (int j = 0; j < 4; j++) clk_bit(1'b1, s);
    i2c_stop();
    check("abort_busy", int'(busy_o), 0);
    check("abort_oen", int'(sda_padoen_o), 1);
    rd_txn(1'b0, 8'h00, 1);

    // Reset in the middle of a read while the slave is pulling SDA low.
    wdata_q = '{8'h3C};
    wr_txn(8'h02);
    i2c_start();
    write_byte(8'hA0, a);
    write_byte(8'h02, a);
    i2c_start();
    write_byte(8'hA1, a);
    check("rstmid_addr_ack", int'(a), 1);
    clk_bit(1'b1, s);
    check("rstmid_bit7", int'(s), 0);
    repeat (5) @(negedge clk);
    check("rstmid_driving", int'(sda_padoen_o), 0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("rstmid_release", int'(sda_padoen_o), 1);
    check("rstmid_busy", int'(busy_o), 0);
    for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
    m_ptr = 0;
    i2c_stop();
    rd_txn(1'b1, 8'h00, 16);

    repeat (10) @(negedge clk);
    check("pending_wr", wr_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
